fetch_queue: RTL
================

# fetch_queue

Instruction buffer between the fetch stage (PC register plus instruction ROM) and the decode stage's IF/ID register. Captures each fetched {pc, instr} pair into a DEPTH-entry circular FIFO and presents the oldest pair to decode. Decode stalls are absorbed without immediately freezing fetch. Fetch back-pressure uses `in_ready`, which drives the fetch stage's PC enable. Branch/jump redirects discard all buffered entries with `flush`.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `PTR_W`, 2: log2(DEPTH); pointer width.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: fetch stage presents a valid pair this cycle.
- `in_pc` input 32: PC of the fetched instruction.
- `in_instr` input 32: fetched instruction word.
- `in_ready` output 1: queue can accept a push this cycle; drives the fetch PC enable.
- `out_valid` output 1: head entry valid.
- `out_pc` output 32: PC of the head entry.
- `out_instr` output 32: head instruction word.
- `out_ready` input 1: decode consumes the head this cycle.
- `flush` input 1: discard all entries (redirect).
- `count` output PTR_W+1: number of occupied entries, 0..DEPTH.

## Operation
- State:
  - `wr_ptr`, `rd_ptr` (PTR_W bits each).
  - `count` register.
  - Storage: DEPTH × 64 bits holding {pc, instr}. Storage is not reset.
- Push: `in_valid && in_ready && !flush`. Writes {in_pc, in_instr} at `wr_ptr`. Then `wr_ptr <= wr_ptr+1`, wrapping modulo DEPTH.
- Pop: `out_valid && out_ready && !flush`. Then `rd_ptr <= rd_ptr+1`, wrapping modulo DEPTH.
- `count` update:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
  - neither: unchanged.
- `in_ready = (count != DEPTH)`. Combinational from registered `count` only, with no path from `out_ready`. A full queue therefore refuses a push even when a pop happens in the same cycle.
- `out_valid = (count != 0)`.
- Head outputs: `out_pc`/`out_instr` = storage[`rd_ptr`] when `out_valid`. When empty they are forced to 0; 0x00000000 is a nop for decode.
- No bypass: a pair pushed into an empty queue becomes visible only on the next cycle.
- Flush is synchronous. On the next edge:
  - `wr_ptr`, `rd_ptr` and `count` all go to 0.
  - A push or pop requested in the flush cycle is discarded.
  - `in_ready` is 1 and `out_valid` is 0 from the cycle after flush.
- Reset (asynchronous, `reset`=0) forces `wr_ptr`=0, `rd_ptr`=0 and `count`=0 immediately, regardless of `clk`. This holds mid-operation, with buffered entries lost. While in reset: `out_valid`=0, `out_pc`=0, `out_instr`=0, `in_ready`=1, `count`=0.
- Reset deassertion is used synchronously by the surrounding design. The first push can occur on the first rising edge after `reset` returns to 1.
- Pushing while `in_ready`=0 is ignored; the fetch PC is held by the enable. Popping while `out_valid`=0 is ignored.

## Timing
- Push→visible latency: 1 cycle. A pair pushed at edge N appears on `out_*` with `out_valid`=1 after edge N when the queue was empty.
- Pop latency: the head advances at the edge where the pop is accepted; the next entry appears in the same cycle after that edge.
- `count`, `in_ready` and `out_valid` all change only on `clk` edges or asynchronously on reset.
- Sustained throughput: 1 push + 1 pop per cycle whenever 0 < count < DEPTH.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble and no change in ordering.
- Full + `out_ready`=1: pop accepted, push refused. `count` drops to DEPTH−1 and `in_ready`=1 the next cycle.
- Empty + `in_valid`=1 + `out_ready`=1: push accepted, no pop. `count`=1 the next cycle.
- Flush has priority over every simultaneous push/pop. Reset has priority over flush.

## Test plan
- Fill: 4 consecutive pushes, pc 0x3000/0x3004/0x3008/0x300C, `out_ready`=0 → `count` steps 1,2,3,4. `in_ready`=0 after the 4th edge. `out_pc`=0x3000 throughout.
- Drain in order: from full, hold `out_ready`=1 for 4 cycles → `out_pc` sequence 0x3000, 0x3004, 0x3008, 0x300C. Then `out_valid`=0, `out_instr`=0, `count`=0.
- Streaming wrap: push and pop every cycle for 10 cycles starting with count=2 → `count` stays 2. Pointers wrap twice. Output PCs are strictly the input PCs delayed by 2 entries.
- Full boundary: count=4, `in_valid`=1, `out_ready`=1 → pop only. The pushed pc 0x3010 is not stored. `count`=3 and `in_ready`=1 next cycle.
- Flush: count=3, assert `flush` with `in_valid`=1 and `out_ready`=1 → next cycle `count`=0, `out_valid`=0, `in_ready`=1. A subsequent push of 0x4000 is the first pair out.
- Async reset mid-stream: count=2, drop `reset` between clock edges → `count`=0, `out_valid`=0 and `out_pc`=0 immediately. After release, a push of 0x3000 emerges after one edge.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction buffer between the fetch stage and decode's IF/ID
// register. Holds up to DEPTH {pc, instr} pairs in a circular FIFO, shows the
// oldest pair to decode, throttles fetch through in_ready and drops every
// buffered pair on a redirect flush.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    input  logic             out_ready,
    input  logic             flush,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] EMPTY_COUNT = '0;

    // Pointers and occupancy; pointers wrap for free because DEPTH is 2**PTR_W.
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;

    // Accepted transfers this cycle (flush vetoes both).
    logic push;
    logic pop;

    // Pair storage, {pc, instr} per entry. Not reset: a stale entry is never
    // visible because the head is masked whenever the queue is empty.
    logic [63:0] mem [DEPTH];
    logic [63:0] head_entry;

    // Handshake flags come from registered count only, so in_ready has no
    // combinational path from out_ready; a full queue refuses a push even
    // if decode pops in the same cycle.
    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != EMPTY_COUNT);
    assign count     = count_reg;

    assign push = in_valid  && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Head is read straight from storage so a pop exposes the next pair in the
    // cycle right after the edge; empty queue shows an all-zero nop.
    assign head_entry = mem[rd_ptr_reg];
    assign out_pc     = out_valid ? head_entry[63:32] : 32'h0000_0000;
    assign out_instr  = out_valid ? head_entry[31:0]  : 32'h0000_0000;

    // Next-state for pointers and occupancy; flush wins over push and pop.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    // Control state; reset clears it immediately, independent of clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Write the incoming pair into the tail slot on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_pc, in_instr};
        end
    end

endmodule
